// File: rtl/key_pkg.sv
// Shared types and default timing constants for the key debounce bank.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESSED,
    LONG
  } key_state_e;

  // Defaults assume a 12 MHz clock.
  localparam int unsigned DEF_N_KEYS        = 4;
  localparam int unsigned DEF_STABLE_CYCLES = 60000;     // 5 ms
  localparam int unsigned DEF_LONG_CYCLES   = 12000000;  // 1 s
  localparam int unsigned DEF_REPEAT_CYCLES = 2400000;   // 200 ms
  localparam int unsigned DEF_ACTIVE_LOW    = 1;

endpackage

// File: rtl/key_debounce_cell.sv
// One key channel: 2-flop synchroniser, debounce filter, press/long-press FSM.
// Optional auto-repeat while held long is enabled by defining KEY_REPEAT_EN.
module key_debounce_cell
  import key_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_level,
  output logic o_neg,
  output logic o_pos,
  output logic o_long
);

  localparam int unsigned CW = $clog2(LONG_CYCLES + 1);
  localparam logic RAW_RELEASED = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          level_q, level_d;
  logic          neg_q, neg_d;
  logic          pos_q, pos_d;
  logic          long_q, long_d;
  key_state_e    state_q, state_d;
  logic          s_pressed;
  logic          rise, fall;
  logic          rep_pulse;

  assign s_pressed = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

`ifdef KEY_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] REP_ONE  = RW'(1);

  logic [RW-1:0] rep_q, rep_d;

  // Repeat counter runs only while in LONG, so it starts from 0 on entry.
  always_comb begin
    rep_d     = '0;
    rep_pulse = 1'b0;
    if (state_q == LONG && !fall) begin
      if (rep_q == REP_LAST) begin
        rep_pulse = 1'b1;
      end else begin
        rep_d = rep_q + REP_ONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

  always_comb begin
    sync1_d   = i_key;
    sync2_d   = sync1_q;
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;

    if (s_pressed == level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == STABLE_LAST) begin
      deb_cnt_d = '0;
      level_d   = ~level_q;
    end else begin
      deb_cnt_d = deb_cnt_q + CNT_ONE;
    end

    rise = level_d & ~level_q;
    fall = ~level_d & level_q;

    state_d = state_q;
    hold_d  = hold_q;
    long_d  = 1'b0;

    unique case (state_q)
      RELEASED: begin
        if (rise) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_d = RELEASED;
        end else if (hold_q == LONG_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
          hold_d  = hold_q + CNT_ONE;
        end else begin
          hold_d = hold_q + CNT_ONE;
        end
      end
      LONG: begin
        // hold_q stays saturated at LONG_CYCLES here
        if (fall) begin
          state_d = RELEASED;
        end
      end
      default: begin
        state_d = RELEASED;
      end
    endcase

    neg_d = rise | rep_pulse;
    pos_d = fall;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q   <= RAW_RELEASED;
      sync2_q   <= RAW_RELEASED;
      deb_cnt_q <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      neg_q     <= 1'b0;
      pos_q     <= 1'b0;
      long_q    <= 1'b0;
      state_q   <= RELEASED;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_cnt_q <= deb_cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      neg_q     <= neg_d;
      pos_q     <= pos_d;
      long_q    <= long_d;
      state_q   <= state_d;
    end
  end

  assign o_level = level_q;
  assign o_neg   = neg_q;
  assign o_pos   = pos_q;
  assign o_long  = long_q;

endmodule

// File: rtl/key_debounce_bank.sv
// Bank of N_KEYS independent debounced key channels plus an any-pressed flag.
// Define KEY_REPEAT_EN to enable auto-repeat on o_neg while a key is held long.
module key_debounce_bank
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS        = DEF_N_KEYS,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_neg,
  output logic [N_KEYS-1:0] o_pos,
  output logic [N_KEYS-1:0] o_long,
  output logic              o_any
);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce_cell #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_cell (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_key   (i_key[k]),
      .o_level (o_level[k]),
      .o_neg   (o_neg[k]),
      .o_pos   (o_pos[k]),
      .o_long  (o_long[k])
    );
  end

  assign o_any = |o_level;

endmodule

// File: tb/tb_key_debounce_bank.sv
// Scoreboard bench for key_debounce_bank with short timing parameters.
module tb_key_debounce_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic [1:0] level, neg, pos, lng;
  logic       any;

  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    int unsigned cyc;
    bit          is_lvl;  // 1: check level/any; 0: check pulse vectors
    logic [1:0]  a;       // neg, or expected level
    logic [1:0]  b;       // pos, or {1'b0, expected any}
    logic [1:0]  c;       // long
  } exp_t;

  exp_t sb[$];

  key_debounce_bank #(
    .N_KEYS        (2),
    .STABLE_CYCLES (4),
    .LONG_CYCLES   (20),
    .REPEAT_CYCLES (8),
    .ACTIVE_LOW    (1)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_key   (key),
    .o_level (level),
    .o_neg   (neg),
    .o_pos   (pos),
    .o_long  (lng),
    .o_any   (any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_pulse(input int unsigned c, input logic [1:0] n, input logic [1:0] p,
                            input logic [1:0] l);
    exp_t e;
    e.cyc = c; e.is_lvl = 1'b0; e.a = n; e.b = p; e.c = l;
    sb.push_back(e);
  endtask

  task automatic push_level(input int unsigned c, input logic [1:0] lv, input logic an);
    exp_t e;
    e.cyc = c; e.is_lvl = 1'b1; e.a = lv; e.b = {1'b0, an}; e.c = 2'b00;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_event: expected at cycle %0d (lvl=%0b a=%b b=%b c=%b), not seen by %0d",
               e.cyc, e.is_lvl, e.a, e.b, e.c, cyc);
    end
    if (sb.size() > 0 && sb[0].is_lvl && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      tests++;
      if (level !== e.a || any !== e.b[0]) begin
        fails++;
        $display("FAIL level_check @%0d: got level=%b any=%b, want level=%b any=%b",
                 cyc, level, any, e.a, e.b[0]);
      end
    end
    if ((|neg) || (|pos) || (|lng)) begin
      tests++;
      if (sb.size() == 0 || sb[0].is_lvl) begin
        fails++;
        $display("FAIL unexpected_pulse @%0d: got neg=%b pos=%b long=%b", cyc, neg, pos, lng);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || neg !== e.a || pos !== e.b || lng !== e.c) begin
          fails++;
          $display("FAIL pulse_check @%0d: got neg=%b pos=%b long=%b, want @%0d neg=%b pos=%b long=%b",
                   cyc, neg, pos, lng, e.cyc, e.a, e.b, e.c);
        end
      end
    end
  end

  initial begin
    int unsigned p;
    rst = 1'b1;
    key = 2'b11;
    push_level(2, 2'b00, 1'b0);
    wait_to(4);
    rst = 1'b0;
    wait_to(8);

    // Clean press and release of key 0.
    p = cyc;
    key[0] = 1'b0;
    push_pulse(p + 6, 2'b01, 2'b00, 2'b00);
    push_level(p + 7, 2'b01, 1'b1);
    wait_to(p + 10);
    key[0] = 1'b1;
    push_pulse(p + 16, 2'b00, 2'b01, 2'b00);
    wait_to(p + 22);

    // Bounce: low 3, high 1, then low held.
    p = cyc;
    key[0] = 1'b0;
    wait_to(p + 3);
    key[0] = 1'b1;
    wait_to(p + 4);
    key[0] = 1'b0;
    push_pulse(p + 10, 2'b01, 2'b00, 2'b00);
    wait_to(p + 14);
    key[0] = 1'b1;
    push_pulse(p + 20, 2'b00, 2'b01, 2'b00);
    wait_to(p + 26);

    // Long press, released 40 cycles after o_neg.
    p = cyc;
    key[0] = 1'b0;
    push_pulse(p + 6, 2'b01, 2'b00, 2'b00);
    push_pulse(p + 26, 2'b00, 2'b00, 2'b01);
`ifdef KEY_REPEAT_EN
    push_pulse(p + 34, 2'b01, 2'b00, 2'b00);
    push_pulse(p + 42, 2'b01, 2'b00, 2'b00);
    push_pulse(p + 50, 2'b01, 2'b00, 2'b00);
`endif
    wait_to(p + 46);
    key[0] = 1'b1;
    push_pulse(p + 52, 2'b00, 2'b01, 2'b00);
    wait_to(p + 58);

    // Both keys together, reset mid-hold, re-press after reset.
    p = cyc;
    key = 2'b00;
    push_pulse(p + 6, 2'b11, 2'b00, 2'b00);
    push_level(p + 9, 2'b11, 1'b1);
    push_level(p + 12, 2'b00, 1'b0);
    push_pulse(p + 19, 2'b11, 2'b00, 2'b00);
    wait_to(p + 10);
    rst = 1'b1;
    wait_to(p + 13);
    rst = 1'b0;
    wait_to(p + 24);
    key = 2'b11;
    push_pulse(p + 30, 2'b00, 2'b11, 2'b00);
    push_level(p + 32, 2'b00, 1'b0);
    wait_to(p + 40);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
